// File: rtl/slave_port_pkg.sv
// Shared state encoding and default widths for the burst slave port.
// Also holds the reset level of slave_ready, which comes out of reset high.
package slave_port_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  localparam logic SLAVE_READY_RST = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    RX_ADDR,
    CHECK,
    WR_WAIT,
    RX_DATA,
    MEM_WR,
    MEM_RD,
    TX_WAIT,
    TX
  } state_t;

endpackage

// File: rtl/slave_shift_reg.sv
// Serial-in/parallel-out and parallel-load/serial-out shift register, LSB first.
// The bit counter wraps after WIDTH shifts; o_done marks the final bit.
module slave_shift_reg
  import slave_port_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_serial_in,
  input  logic [WIDTH-1:0] i_load_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_serial,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_cnt;

  // New bits enter at the MSB so the first received bit ends up in bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_data <= {i_serial_in, r_data[WIDTH-1:1]};
      r_cnt  <= o_done ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_data   = r_data;
  assign o_serial = r_data[0];
  assign o_done   = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/burst_slave_port.sv
// Serial bus slave port with multi-beat bursts and address auto-increment.
// Bridges the serial system bus to a wait-stated memory handshake.
module burst_slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_W    = 4,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [BURST_W-1:0]    burst_len,
  input  logic                  master_valid,
  input  logic                  master_ready,
  input  logic                  rx_address,
  input  logic                  rx_data,
  output logic                  slave_ready,
  output logic                  slave_valid,
  output logic                  tx_data,
  output logic                  rx_done,
  output logic                  slave_tx_done,
  output logic                  addr_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  input  logic                  mem_ready
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t                r_state;
  logic                  r_is_read;
  logic [BURST_W-1:0]    r_burst_len;
  logic [BURST_W-1:0]    r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_slave_ready;
  logic                  r_slave_valid;
  logic                  r_rx_done;
  logic                  r_addr_err;
  logic                  r_busy;
  logic                  r_mem_read_en;
  logic                  r_mem_write_en;

  logic                  w_start;
  logic                  w_addr_shift;
  logic                  w_data_shift;
  logic                  w_tx_shift;
  logic                  w_tx_load;
  logic                  w_addr_clear;
  logic                  w_data_clear;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data_par;
  logic [DATA_WIDTH-1:0] w_tx_par;
  logic                  w_addr_serial;
  logic                  w_data_serial;
  logic                  w_tx_serial;
  logic                  w_addr_done;
  logic                  w_data_done;
  logic                  w_tx_done;
  logic [ADDR_WIDTH:0]   w_addr_ext;
  logic [ADDR_WIDTH:0]   w_addr_end;
  logic                  w_range_bad;
  logic                  w_last_beat;
  logic                  w_unused;

  assign w_start      = master_valid & (read_en ^ write_en);
  assign w_addr_shift = (r_state == RX_ADDR);
  assign w_data_shift = (r_state == RX_DATA);
  assign w_tx_shift   = (r_state == TX);
  assign w_tx_load    = (r_state == MEM_RD) & mem_ready;
  assign w_addr_clear = (r_state == IDLE) & w_start;
  assign w_data_clear = (r_state == WR_WAIT) & master_valid;

  // One extra bit keeps base + burst length from wrapping past the top.
  assign w_addr_ext  = {1'b0, w_addr};
  assign w_addr_end  = w_addr_ext + (ADDR_WIDTH + 1)'(r_burst_len);
  assign w_range_bad = (w_addr_ext >= LP_DEPTH) || (w_addr_end >= LP_DEPTH);
  assign w_last_beat = (r_beat_cnt == r_burst_len);

  slave_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_addr_clear),
    .i_load      (1'b0),
    .i_shift     (w_addr_shift),
    .i_serial_in (rx_address),
    .i_load_data ('0),
    .o_data      (w_addr),
    .o_serial    (w_addr_serial),
    .o_done      (w_addr_done)
  );

  slave_shift_reg #(.WIDTH(DATA_WIDTH)) u_data_sr (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_data_clear),
    .i_load      (1'b0),
    .i_shift     (w_data_shift),
    .i_serial_in (rx_data),
    .i_load_data ('0),
    .o_data      (w_data_par),
    .o_serial    (w_data_serial),
    .o_done      (w_data_done)
  );

  slave_shift_reg #(.WIDTH(DATA_WIDTH)) u_tx_sr (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (1'b0),
    .i_load      (w_tx_load),
    .i_shift     (w_tx_shift),
    .i_serial_in (1'b0),
    .i_load_data (mem_rdata),
    .o_data      (w_tx_par),
    .o_serial    (w_tx_serial),
    .o_done      (w_tx_done)
  );

  // Shift register taps that this port never consumes.
  assign w_unused = ^{w_addr_serial, w_data_serial, w_data_par[0], w_tx_par};

  // Outputs are updated in the same branch that moves the state, so they track it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_is_read      <= 1'b0;
      r_burst_len    <= '0;
      r_beat_cnt     <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_slave_ready  <= SLAVE_READY_RST;
      r_slave_valid  <= 1'b0;
      r_rx_done      <= 1'b0;
      r_addr_err     <= 1'b0;
      r_busy         <= 1'b0;
      r_mem_read_en  <= 1'b0;
      r_mem_write_en <= 1'b0;
    end else begin
      r_rx_done  <= 1'b0;
      r_addr_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state       <= RX_ADDR;
            r_is_read     <= read_en;
            r_burst_len   <= burst_len;
            r_beat_cnt    <= '0;
            r_slave_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        RX_ADDR: begin
          if (w_addr_done) r_state <= CHECK;
        end
        CHECK: begin
          if (w_range_bad) begin
            r_state       <= IDLE;
            r_addr_err    <= 1'b1;
            r_slave_ready <= 1'b1;
            r_busy        <= 1'b0;
          end else begin
            r_mem_addr <= w_addr;
            if (r_is_read) begin
              r_state       <= MEM_RD;
              r_rx_done     <= 1'b1;
              r_mem_read_en <= 1'b1;
            end else begin
              r_state       <= WR_WAIT;
              r_slave_ready <= 1'b1;
            end
          end
        end
        WR_WAIT: begin
          if (master_valid) begin
            r_state       <= RX_DATA;
            r_slave_ready <= 1'b0;
          end
        end
        RX_DATA: begin
          if (w_data_done) begin
            r_state        <= MEM_WR;
            r_rx_done      <= 1'b1;
            r_mem_wdata    <= {rx_data, w_data_par[DATA_WIDTH-1:1]};
            r_mem_write_en <= 1'b1;
          end
        end
        MEM_WR: begin
          if (mem_ready) begin
            r_mem_write_en <= 1'b0;
            r_slave_ready  <= 1'b1;
            if (w_last_beat) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= WR_WAIT;
              r_beat_cnt <= r_beat_cnt + BURST_W'(1);
              r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            end
          end
        end
        MEM_RD: begin
          if (mem_ready) begin
            r_state       <= TX_WAIT;
            r_mem_read_en <= 1'b0;
            r_slave_valid <= 1'b1;
          end
        end
        TX_WAIT: begin
          if (master_ready) r_state <= TX;
        end
        TX: begin
          if (w_tx_done) begin
            r_slave_valid <= 1'b0;
            if (w_last_beat) begin
              r_state       <= IDLE;
              r_slave_ready <= 1'b1;
              r_busy        <= 1'b0;
            end else begin
              r_state       <= MEM_RD;
              r_mem_read_en <= 1'b1;
              r_beat_cnt    <= r_beat_cnt + BURST_W'(1);
              r_mem_addr    <= r_mem_addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign slave_ready   = r_slave_ready;
  assign slave_valid   = r_slave_valid;
  assign tx_data       = w_tx_shift & w_tx_serial;
  assign rx_done       = r_rx_done;
  assign slave_tx_done = w_tx_shift & w_tx_done;
  assign addr_err      = r_addr_err;
  assign busy          = r_busy;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_read_en   = r_mem_read_en;
  assign mem_write_en  = r_mem_write_en;

endmodule

// File: tb/tb_burst_slave_port.sv
// Directed bench for burst_slave_port: writes, read burst with wait states,
// range errors, illegal starts and an asynchronous reset in the middle of a read.
module tb_burst_slave_port;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 2048;

  logic          clk;
  logic          reset;
  logic          read_en;
  logic          write_en;
  logic [BW-1:0] burst_len;
  logic          master_valid;
  logic          master_ready;
  logic          rx_address;
  logic          rx_data;
  logic          slave_ready;
  logic          slave_valid;
  logic          tx_data;
  logic          rx_done;
  logic          slave_tx_done;
  logic          addr_err;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_read_en;
  logic          mem_write_en;
  logic          mem_ready;

  int testCount    = 0;
  int failCount    = 0;
  int wrCycles     = 0;
  int rdCycles     = 0;
  int rxDonePulses = 0;
  int txDonePulses = 0;
  int errPulses    = 0;

  int wr0, rd0, rx0, tx0, err0;

  burst_slave_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_W    (BW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .read_en       (read_en),
    .write_en      (write_en),
    .burst_len     (burst_len),
    .master_valid  (master_valid),
    .master_ready  (master_ready),
    .rx_address    (rx_address),
    .rx_data       (rx_data),
    .slave_ready   (slave_ready),
    .slave_valid   (slave_valid),
    .tx_data       (tx_data),
    .rx_done       (rx_done),
    .slave_tx_done (slave_tx_done),
    .addr_err      (addr_err),
    .busy          (busy),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_read_en   (mem_read_en),
    .mem_write_en  (mem_write_en),
    .mem_ready     (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse and request-cycle counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_write_en)  wrCycles++;
      if (mem_read_en)   rdCycles++;
      if (rx_done)       rxDonePulses++;
      if (slave_tx_done) txDonePulses++;
      if (addr_err)      errPulses++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no completion, required finish before timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  // {slave_ready, slave_valid, tx_data, rx_done, slave_tx_done, addr_err, busy, mem_read_en, mem_write_en}
  function automatic logic [8:0] ctrlBits();
    return {slave_ready, slave_valid, tx_data, rx_done, slave_tx_done,
            addr_err, busy, mem_read_en, mem_write_en};
  endfunction

  task automatic snapshot();
    wr0  = wrCycles;
    rd0  = rdCycles;
    rx0  = rxDonePulses;
    tx0  = txDonePulses;
    err0 = errPulses;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic mv, input logic [BW-1:0] blen);
    read_en      = rd;
    write_en     = wr;
    master_valid = mv;
    burst_len    = blen;
    tick();
    read_en      = 1'b0;
    write_en     = 1'b0;
    master_valid = 1'b0;
    burst_len    = '0;
  endtask

  // Start a transaction and shift the address in; returns sampled in CHECK.
  task automatic startTxn(input logic rd, input logic [AW-1:0] addr, input logic [BW-1:0] blen);
    applyStimulus(rd, ~rd, 1'b1, blen);
    checkOutput("start_ready_low", slave_ready, 0);
    for (int i = 0; i < AW; i++) begin
      rx_address = addr[i];
      tick();
    end
    rx_address = 1'b0;
    checkOutput("check_busy", busy, 1);
  endtask

  // Entered while in WR_WAIT; leaves after the memory write is accepted.
  task automatic writeBeat(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic last);
    checkOutput("wr_wait_ready", slave_ready, 1);
    master_valid = 1'b1;
    tick();
    master_valid = 1'b0;
    checkOutput("rx_data_ready", slave_ready, 0);
    for (int i = 0; i < DW; i++) begin
      rx_data = data[i];
      tick();
    end
    rx_data = 1'b0;
    checkOutput("wr_rx_done", rx_done, 1);
    checkOutput("wr_en", mem_write_en, 1);
    checkOutput("wr_addr", mem_addr, addr);
    checkOutput("wr_data", mem_wdata, data);
    tick();
    checkOutput("wr_en_drop", mem_write_en, 0);
    checkOutput("wr_busy_after", busy, !last);
    checkOutput("wr_ready_after", slave_ready, 1);
  endtask

  // Entered while in MEM_RD; leaves after the beat is fully transmitted.
  task automatic readBeat(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int memLate, input int masterLate, input logic last);
    checkOutput("rd_req", mem_read_en, 1);
    checkOutput("rd_addr", mem_addr, addr);
    mem_ready = 1'b0;
    repeat (memLate) tick();
    checkOutput("rd_hold", mem_read_en, 1);
    mem_ready = 1'b1;
    mem_rdata = data;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 8'hEE;
    checkOutput("txw_valid", slave_valid, 1);
    checkOutput("rd_release", mem_read_en, 0);
    checkOutput("txw_tx_zero", tx_data, 0);
    repeat (masterLate) tick();
    checkOutput("txw_valid_hold", slave_valid, 1);
    master_ready = 1'b1;
    tick();
    master_ready = 1'b0;
    for (int i = 0; i < DW; i++) begin
      checkOutput("tx_bit", tx_data, data[i]);
      checkOutput("tx_done", slave_tx_done, (i == DW - 1) ? 1 : 0);
      checkOutput("tx_valid", slave_valid, 1);
      tick();
    end
    checkOutput("tx_valid_drop", slave_valid, 0);
    checkOutput("rd_busy_after", busy, !last);
    mem_ready = 1'b1;
  endtask

  initial begin
    reset        = 1'b1;
    read_en      = 1'b0;
    write_en     = 1'b0;
    burst_len    = '0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    rx_address   = 1'b0;
    rx_data      = 1'b0;
    mem_rdata    = '0;
    mem_ready    = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", ctrlBits(), 9'b1_0000_0000);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_wdata", mem_wdata, 0);
    reset = 1'b0;
    tick();
    checkOutput("post_reset_busy", busy, 0);
    checkOutput("post_reset_ready", slave_ready, 1);

    // Illegal starts
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("illegal_both_busy", busy, 0);
    checkOutput("illegal_both_ready", slave_ready, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("illegal_novalid_busy", busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    checkOutput("illegal_neither_busy", busy, 0);

    // Single write
    snapshot();
    startTxn(1'b0, 12'h0A5, 4'd0);
    tick();
    writeBeat(12'h0A5, 8'h3C, 1'b1);
    checkOutput("sw_wr_cycles", wrCycles - wr0, 1);
    checkOutput("sw_rx_done_cnt", rxDonePulses - rx0, 1);
    checkOutput("sw_rd_cycles", rdCycles - rd0, 0);

    // Two-beat write burst with address increment
    snapshot();
    startTxn(1'b0, 12'h100, 4'd1);
    tick();
    writeBeat(12'h100, 8'h81, 1'b0);
    writeBeat(12'h101, 8'h7E, 1'b1);
    checkOutput("wb_wr_cycles", wrCycles - wr0, 2);
    checkOutput("wb_rx_done_cnt", rxDonePulses - rx0, 2);

    // Highest legal address
    snapshot();
    startTxn(1'b0, 12'h7FF, 4'd0);
    tick();
    writeBeat(12'h7FF, 8'hA5, 1'b1);
    checkOutput("top_addr_no_err", errPulses - err0, 0);

    // Range errors: burst crossing the top, and base past the top
    snapshot();
    startTxn(1'b1, 12'h7FE, 4'd3);
    tick();
    checkOutput("err_pulse", addr_err, 1);
    checkOutput("err_ready", slave_ready, 1);
    checkOutput("err_busy", busy, 0);
    tick();
    checkOutput("err_pulse_drop", addr_err, 0);
    startTxn(1'b0, 12'h800, 4'd0);
    tick();
    checkOutput("err_base_pulse", addr_err, 1);
    tick();
    checkOutput("err_cnt", errPulses - err0, 2);
    checkOutput("err_no_rd", rdCycles - rd0, 0);
    checkOutput("err_no_wr", wrCycles - wr0, 0);

    // Read burst with memory and master wait states
    snapshot();
    startTxn(1'b1, 12'h010, 4'd2);
    tick();
    checkOutput("rb_rx_done", rx_done, 1);
    readBeat(12'h010, 8'h11, 2, 3, 1'b0);
    readBeat(12'h011, 8'h22, 2, 3, 1'b0);
    readBeat(12'h012, 8'h33, 2, 3, 1'b1);
    checkOutput("rb_ready_end", slave_ready, 1);
    checkOutput("rb_rd_cycles", rdCycles - rd0, 9);
    checkOutput("rb_tx_done_cnt", txDonePulses - tx0, 3);
    checkOutput("rb_rx_done_cnt", rxDonePulses - rx0, 1);
    checkOutput("rb_wr_cycles", wrCycles - wr0, 0);

    // Asynchronous reset during TX of the second read beat
    startTxn(1'b1, 12'h020, 4'd1);
    tick();
    readBeat(12'h020, 8'h44, 0, 0, 1'b0);
    checkOutput("rr_addr2", mem_addr, 12'h021);
    mem_ready = 1'b1;
    mem_rdata = 8'h55;
    tick();
    mem_rdata = '0;
    master_ready = 1'b1;
    tick();
    master_ready = 1'b0;
    checkOutput("rr_bit0", tx_data, 1);
    tick();
    checkOutput("rr_bit1", tx_data, 0);
    tick();
    checkOutput("rr_bit2", tx_data, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rr_async_ctrl", ctrlBits(), 9'b1_0000_0000);
    checkOutput("rr_async_addr", mem_addr, 0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rr_post_busy", busy, 0);
    checkOutput("rr_post_ready", slave_ready, 1);
    startTxn(1'b0, 12'h001, 4'd0);
    tick();
    writeBeat(12'h001, 8'h5A, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
